uart_write_ctrl: RTL
====================

UART_WRITE_CTRL -- requirements
Module: uart_write_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, memory address width (depth = 2**ADDR_WIDTH = 16).
REQ-002 SHALL have parameter AFULL_LVL, default 12, fill level at or above which almost_full asserts.
REQ-003 SHALL have port uart_clk  input  1  write-domain clock; the block has one clock only.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port push  input  1  write request from the UART receiver.
REQ-006 SHALL have port r_ptr_gray  input  ADDR_WIDTH+1  read pointer in Gray code from the processor domain; asynchronous to uart_clk.
REQ-007 SHALL have port clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-008 SHALL have port wr_en  output  1  write strobe to the dual-port RAM.
REQ-009 SHALL have port w_add  output  ADDR_WIDTH  RAM write address.
REQ-010 SHALL have port w_ptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, for synchronisation into the processor domain.
REQ-011 SHALL have port comp_full  output  1  FIFO full flag.
REQ-012 SHALL have port almost_full  output  1  fill level >= AFULL_LVL.
REQ-013 SHALL have port fill_lvl  output  ADDR_WIDTH+1  pessimistic occupancy, range 0..16.
REQ-014 SHALL have port overflow  output  1  sticky flag: a push was attempted while full.

Function
REQ-015 SHALL keep an internal binary write pointer w_ptr of ADDR_WIDTH+1 bits; the MSB is the wrap bit.
REQ-016 SHALL synchronise r_ptr_gray through two flops clocked by uart_clk; no other logic between them.
REQ-017 SHALL convert the synchronised Gray value to binary (r_ptr_sync) using MSB pass-through and XOR cascade.
REQ-018 SHALL accept a push when push=1 and comp_full=0; wr_en = push & ~comp_full, combinational in the same cycle.
REQ-019 SHALL increment w_ptr by 1 on the rising edge ending an accepted push; wrap from 2*depth-1 to 0 is modulo 2**(ADDR_WIDTH+1).
REQ-020 SHALL drive w_add = w_ptr[ADDR_WIDTH-1:0], so data written with wr_en goes to the pre-increment address.
REQ-021 SHALL register w_ptr_gray = w_ptr ^ (w_ptr >> 1), updated on the same edge as w_ptr; it changes one bit per increment.
REQ-022 SHALL assert comp_full when w_ptr[MSB] != r_ptr_sync[MSB] and the lower ADDR_WIDTH bits are equal; this is decoded from registers only, with no path from push.
REQ-023 SHALL compute fill_lvl = (w_ptr - r_ptr_sync) modulo 2**(ADDR_WIDTH+1), decoded from registers.
REQ-024 SHALL assert almost_full when fill_lvl >= AFULL_LVL; comp_full=1 implies almost_full=1.
REQ-025 SHALL set overflow on the edge after push=1 while comp_full=1; the dropped push leaves w_ptr unchanged.
REQ-026 SHALL give set priority over clear when overflow would be set and cleared in the same cycle; clr_ovf alone clears overflow on the next edge.
REQ-027 SHALL see a read-side pointer advance after 2 to 3 uart_clk edges; full release is therefore delayed, which is pessimistic and safe.
REQ-028 SHALL, on simultaneous push and full release, honour comp_full as sampled in that cycle; push is accepted only if comp_full=0.

Reset
REQ-029 SHALL, on reset=0 and independent of uart_clk, clear w_ptr, w_ptr_gray, both sync flops and overflow to 0.
REQ-030 SHALL, during and after reset, drive outputs w_add=0, w_ptr_gray=0, comp_full=0, almost_full=0, fill_lvl=0, overflow=0, and wr_en=0 unless push=1.
REQ-031 SHALL, when reset is asserted mid-operation, discard any in-flight push; the first edge after deassertion treats the FIFO as empty.
REQ-032 SHALL have reset deassertion synchronised externally; the block does not resynchronise reset.

Verification
REQ-033 Bench SHALL cover: reset, r_ptr_gray=0, 16 consecutive pushes -> w_add 0..15 with wr_en=1, then comp_full=1, fill_lvl=16, w_ptr_gray=5'b11000.
REQ-034 Bench SHALL cover: full state plus a push -> wr_en=0, w_ptr unchanged, overflow=1 next cycle; then clr_ovf=1 -> overflow=0 next cycle.
REQ-035 Bench SHALL cover: full state, r_ptr_gray changed 0 -> 1 -> comp_full deasserts within 3 edges, fill_lvl=15.
REQ-036 Bench SHALL cover: wrap, with 40 pushes against a reader tracking 4 entries behind -> w_ptr_gray Hamming distance 1 per push, and w_add wraps 15->0 at pushes 16 and 32.
REQ-037 Bench SHALL cover: fill to 12 entries -> almost_full=1; reader advances to 11 entries -> almost_full=0 after sync latency.
REQ-038 Bench SHALL cover: reset=0 pulsed mid-burst, asynchronous to uart_clk -> all outputs 0 immediately, with no wr_en while reset=0 except combinational push.

Source files
------------

// File: rtl/uart_write_ctrl.sv
// uart_write_ctrl: write-side controller of an async FIFO, clocked by uart_clk.
// Synchronises the Gray read pointer and derives full, fill level and overflow.
module uart_write_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_LVL  = 12
) (
    input  logic                  uart_clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [ADDR_WIDTH:0]   r_ptr_gray,
    input  logic                  clr_ovf,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] w_add,
    output logic [ADDR_WIDTH:0]   w_ptr_gray,
    output logic                  comp_full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   fill_lvl,
    output logic                  overflow
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_W = PW'(AFULL_LVL);

    logic [PW-1:0] w_ptr_q, w_ptr_d;
    logic [PW-1:0] w_gray_q, w_gray_d;
    logic [PW-1:0] sync1_q, sync2_q;
    logic [PW-1:0] r_ptr_sync;
    logic          ovf_q, ovf_d;

    always_ff @(posedge uart_clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= r_ptr_gray;
            sync2_q <= sync1_q;
        end
    end

    // Binary bit i is the XOR of all Gray bits from i up to the MSB.
    always_comb begin
        r_ptr_sync = '0;
        for (int i = 0; i < PW; i++)
            r_ptr_sync[i] = ^(sync2_q >> i);
    end

    assign comp_full   = (w_ptr_q[PW-1] != r_ptr_sync[PW-1]) &&
                         (w_ptr_q[ADDR_WIDTH-1:0] == r_ptr_sync[ADDR_WIDTH-1:0]);
    assign fill_lvl    = w_ptr_q - r_ptr_sync;
    assign almost_full = comp_full | (fill_lvl >= AFULL_W);
    assign wr_en       = push & ~comp_full;
    assign w_add       = w_ptr_q[ADDR_WIDTH-1:0];
    assign w_ptr_gray  = w_gray_q;
    assign overflow    = ovf_q;

    always_comb begin
        w_ptr_d  = w_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_en};
        w_gray_d = w_ptr_d ^ (w_ptr_d >> 1);
        ovf_d    = (push & comp_full) | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge uart_clk or negedge reset) begin
        if (!reset) begin
            w_ptr_q  <= '0;
            w_gray_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            w_ptr_q  <= w_ptr_d;
            w_gray_q <= w_gray_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule
